// File: rtl/rom_loader_pkg.sv
// Shared definitions for the ROM loader: FSM state encoding and length-field size.
package rom_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    WRITE,
    VERIFY,
    DONE,
    ERR
  } state_t;

  localparam int unsigned LEN_BYTES  = 4;
  localparam int unsigned BYTE_CNT_W = 2;

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte-to-word packer: 4-byte shift register with a word-complete strobe.
module byte_packer
  import rom_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word_c,
  output logic        word_valid_c
);

  logic [31:0]           shreg;
  logic [BYTE_CNT_W-1:0] cnt;
  logic                  unused_oldest;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (clear) begin
      cnt   <= '0;
    end else if (byte_valid) begin
      shreg <= {byte_data, shreg[31:8]};
      cnt   <= cnt + BYTE_CNT_W'(1);
    end
  end

  // The word completes in the same cycle its last byte arrives, so the FSM can act on it immediately.
  assign word_c        = {byte_data, shreg[31:8]};
  assign word_valid_c  = byte_valid && (cnt == BYTE_CNT_W'(LEN_BYTES - 1));
  assign unused_oldest = ^shreg[7:0];

endmodule

// File: rtl/rom_loader.sv
// Boot ROM loader: receives a length-prefixed byte stream and writes it to memory, holding the core in reset.
// Optional readback check after every write is enabled by defining ROM_LOADER_VERIFY_EN.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        writeEnable,
  output logic [31:0] addr,
  output logic [31:0] writeData,
  input  logic [31:0] readData,
  output logic        cpu_rstn,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int unsigned IDX_W = $clog2(MAX_WORDS + 1);

  state_t             state, state_next;
  logic [IDX_W-1:0]   index, index_next;
  logic [IDX_W-1:0]   count, count_next;
  logic [31:0]        addr_next, wdata_next;
  logic               clear_c;
  logic               last_c;
  logic [31:0]        word_c;
  logic               word_valid_c;

  byte_packer u_packer (
    .clk          (clk),
    .rstn         (rstn),
    .clear        (clear_c),
    .byte_valid   (rx_valid && rx_ready),
    .byte_data    (rx_data),
    .word_c       (word_c),
    .word_valid_c (word_valid_c)
  );

  assign last_c = (index == count - IDX_W'(1));

`ifndef ROM_LOADER_VERIFY_EN
  logic unused_read;
  assign unused_read = ^readData;
`endif

  // Next-state and datapath update
  always_comb begin
    state_next = state;
    index_next = index;
    count_next = count;
    addr_next  = addr;
    wdata_next = writeData;
    clear_c    = 1'b0;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_next = LEN;
          clear_c    = 1'b1;
        end
      end
      LEN: begin
        if (word_valid_c) begin
          if (word_c == 32'd0) begin
            state_next = DONE;
          end else if (word_c > 32'(MAX_WORDS)) begin
            state_next = ERR;
          end else begin
            count_next = IDX_W'(word_c);
            index_next = '0;
            state_next = DATA;
          end
        end
      end
      DATA: begin
        if (word_valid_c) begin
          wdata_next = word_c;
          addr_next  = BASE_ADDR + (32'(index) << 2);
          state_next = WRITE;
        end
      end
      WRITE: begin
`ifdef ROM_LOADER_VERIFY_EN
        state_next = VERIFY;
`else
        if (last_c) begin
          state_next = DONE;
        end else begin
          index_next = index + IDX_W'(1);
          state_next = DATA;
        end
`endif
      end
`ifdef ROM_LOADER_VERIFY_EN
      VERIFY: begin
        if (readData != writeData) begin
          state_next = ERR;
        end else if (last_c) begin
          state_next = DONE;
        end else begin
          index_next = index + IDX_W'(1);
          state_next = DATA;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // State register; status outputs are registered from the next state so they line up with it
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      index       <= '0;
      count       <= '0;
      addr        <= '0;
      writeData   <= '0;
      rx_ready    <= 1'b0;
      writeEnable <= 1'b0;
      cpu_rstn    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      state       <= state_next;
      index       <= index_next;
      count       <= count_next;
      addr        <= addr_next;
      writeData   <= wdata_next;
      rx_ready    <= (state_next == LEN) || (state_next == DATA);
      writeEnable <= (state_next == WRITE);
      cpu_rstn    <= (state_next == DONE);
      busy        <= (state_next == LEN) || (state_next == DATA) ||
                     (state_next == WRITE) || (state_next == VERIFY);
      done        <= (state_next == DONE);
      error       <= (state_next == ERR);
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: two instances (BASE_ADDR 0x0 and 0x100) driven by one byte stream.
module tb_rom_loader;

  logic        clk = 1'b0;
  logic        rstn, start, rx_valid, corrupt;
  logic [7:0]  rx_data;

  logic        rdy_a, we_a, cpu_a, busy_a, done_a, err_a;
  logic [31:0] addr_a, wd_a, rd_a;
  logic        rdy_b, we_b, cpu_b, busy_b, done_b, err_b;
  logic [31:0] addr_b, wd_b, rd_b;

  logic [31:0] mem_a [16];
  logic [31:0] mem_b [16];
  logic [31:0] log_addr_a [64], log_data_a [64];
  logic [31:0] log_addr_b [64], log_data_b [64];
  int          wr_a = 0, wr_b = 0;
  int          base_a, base_b;
  int          n_assert = 0, n_fail = 0;

  always #5 clk = ~clk;

  rom_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(4096)) dut_a (
    .clk(clk), .rstn(rstn), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rdy_a), .writeEnable(we_a), .addr(addr_a), .writeData(wd_a),
    .readData(rd_a), .cpu_rstn(cpu_a), .busy(busy_a), .done(done_a), .error(err_a)
  );

  rom_loader #(.BASE_ADDR(32'h0000_0100), .MAX_WORDS(4096)) dut_b (
    .clk(clk), .rstn(rstn), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rdy_b), .writeEnable(we_b), .addr(addr_b), .writeData(wd_b),
    .readData(rd_b), .cpu_rstn(cpu_b), .busy(busy_b), .done(done_b), .error(err_b)
  );

  // Memory models: combinational read, optional forced zero at byte address 0 of instance A
  assign rd_a = (corrupt && addr_a == 32'h0) ? 32'h0 : mem_a[addr_a[5:2]];
  assign rd_b = mem_b[addr_b[5:2]];

  always @(negedge clk) begin
    if (we_a) begin
      mem_a[addr_a[5:2]] <= wd_a;
      if (wr_a < 64) begin
        log_addr_a[wr_a] <= addr_a;
        log_data_a[wr_a] <= wd_a;
      end
      wr_a <= wr_a + 1;
    end
    if (we_b) begin
      mem_b[addr_b[5:2]] <= wd_b;
      if (wr_b < 64) begin
        log_addr_b[wr_b] <= addr_b;
        log_data_b[wr_b] <= wd_b;
      end
      wr_b <= wr_b + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rx_ready"}, 32'(rdy_a), 32'd0);
    check({tag, "_we"},       32'(we_a), 32'd0);
    check({tag, "_addr_a"},   addr_a, 32'd0);
    check({tag, "_addr_b"},   addr_b, 32'd0);
    check({tag, "_wdata"},    wd_a, 32'd0);
    check({tag, "_cpu_rstn"}, 32'(cpu_a), 32'd0);
    check({tag, "_busy"},     32'(busy_a), 32'd0);
    check({tag, "_done"},     32'(done_a), 32'd0);
    check({tag, "_error"},    32'(err_a), 32'd0);
  endtask

  // All tasks start and end just after a falling edge
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rdy_a && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rx_ready_wait", 32'(n < 20), 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    logic [31:0] tmp;
    tmp = w;
    for (int i = 0; i < 4; i++) begin
      send_byte(tmp[8*i +: 8]);
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic wait_status();
    int n = 0;
    while (!(done_a || err_a) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("status_wait", 32'(n < 20), 32'd1);
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; corrupt = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rstn = 1'b1;
    @(negedge clk);
    check("idle_cpu_rstn", 32'(cpu_a), 32'd0);

    // Two-word load at base 0x0 / 0x100
    base_a = wr_a; base_b = wr_b;
    pulse_start();
    check("len_busy", 32'(busy_a), 32'd1);
    check("len_rx_ready", 32'(rdy_a), 32'd1);
    send_word(32'd2, 0);
    send_word(32'h1234_5678, 0);
    send_word(32'hDEAD_BEEF, 0);
    wait_status();
    check("t1_done", 32'(done_a), 32'd1);
    check("t1_cpu_rstn", 32'(cpu_a), 32'd1);
    check("t1_error", 32'(err_a), 32'd0);
    check("t1_busy", 32'(busy_a), 32'd0);
    check("t1_writes", 32'(wr_a - base_a), 32'd2);
    check("t1_addr0", log_addr_a[base_a], 32'h0);
    check("t1_data0", log_data_a[base_a], 32'h1234_5678);
    check("t1_addr1", log_addr_a[base_a+1], 32'h4);
    check("t1_data1", log_data_a[base_a+1], 32'hDEAD_BEEF);

    // Gapped stream; start pulse mid-load must be ignored
    base_a = wr_a; base_b = wr_b;
    pulse_start();
    send_word(32'd2, 3);
    send_word(32'h1122_3344, 3);
    check("gap_busy", 32'(busy_b), 32'd1);
    check("gap_rx_ready", 32'(rdy_b), 32'd1);
    pulse_start();
    check("gap_start_ignored", 32'(busy_b), 32'd1);
    send_word(32'h5566_7788, 3);
    wait_status();
    check("gap_done_b", 32'(done_b), 32'd1);
    check("gap_writes_b", 32'(wr_b - base_b), 32'd2);
    check("gap_addr0_b", log_addr_b[base_b], 32'h100);
    check("gap_data0_b", log_data_b[base_b], 32'h1122_3344);
    check("gap_addr1_b", log_addr_b[base_b+1], 32'h104);
    check("gap_data1_b", log_data_b[base_b+1], 32'h5566_7788);
    check("gap_data1_a", log_data_a[base_a+1], 32'h5566_7788);

    // Zero length: DONE in the cycle after the 4th length byte, no writes
    base_a = wr_a;
    pulse_start();
    check("zero_done_low", 32'(done_a), 32'd0);
    send_word(32'd0, 0);
    check("zero_done", 32'(done_a), 32'd1);
    check("zero_cpu_rstn", 32'(cpu_a), 32'd1);
    check("zero_rx_ready", 32'(rdy_a), 32'd0);
    check("zero_writes", 32'(wr_a - base_a), 32'd0);

    // Oversize length 4097
    base_a = wr_a;
    pulse_start();
    send_word(32'h0000_1001, 0);
    check("big_error", 32'(err_a), 32'd1);
    check("big_done", 32'(done_a), 32'd0);
    check("big_cpu_rstn", 32'(cpu_a), 32'd0);
    repeat (2) @(negedge clk);
    check("big_writes", 32'(wr_a - base_a), 32'd0);

    // Reset after 2nd byte of word 1, then a fresh load
    base_a = wr_a;
    pulse_start();
    send_word(32'd2, 0);
    send_word(32'hAABB_CCDD, 0);
    send_byte(8'h01);
    send_byte(8'h02);
    rstn = 1'b0;
    @(negedge clk);
    check_idle("midreset");
    check("midreset_writes", 32'(wr_a - base_a), 32'd1);
    rstn = 1'b1;
    @(negedge clk);
    pulse_start();
    send_word(32'd1, 0);
    send_word(32'hCAFE_F00D, 0);
    wait_status();
    check("reload_done", 32'(done_a), 32'd1);
    check("reload_writes", 32'(wr_a - base_a), 32'd2);
    check("reload_addr", log_addr_a[base_a+1], 32'h0);
    check("reload_data", log_data_a[base_a+1], 32'hCAFE_F00D);

    // Readback corrupted to zero on instance A
    corrupt = 1'b1;
    pulse_start();
    send_word(32'd1, 0);
    send_word(32'hA5A5_A5A5, 0);
    wait_status();
`ifdef ROM_LOADER_VERIFY_EN
    check("verify_error", 32'(err_a), 32'd1);
    check("verify_done", 32'(done_a), 32'd0);
    check("verify_cpu_rstn", 32'(cpu_a), 32'd0);
    check("verify_done_b", 32'(done_b), 32'd1);
`else
    check("noverify_done", 32'(done_a), 32'd1);
    check("noverify_error", 32'(err_a), 32'd0);
`endif
    corrupt = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, 32'h0000_0000, byte address of first word written.
REQ-002 SHALL have parameter MAX_WORDS, 4096, maximum accepted word count.
REQ-003 SHALL have clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have rstn  input  1  synchronous active-low reset, sampled on posedge clk.
REQ-005 SHALL have start  input  1  one-cycle pulse that begins a load.
REQ-006 SHALL have rx_valid  input  1  byte-stream valid.
REQ-007 SHALL have rx_data  input  8  byte-stream data.
REQ-008 SHALL have rx_ready  output  1  byte-stream ready.
REQ-009 SHALL have writeEnable  output  1  memory write strobe.
REQ-010 SHALL have addr  output  32  memory byte address, word aligned.
REQ-011 SHALL have writeData  output  32  memory write word.
REQ-012 SHALL have readData  input  32  memory combinational read data at addr.
REQ-013 SHALL have cpu_rstn  output  1  active-low core reset; low until load done.
REQ-014 SHALL have busy, done, error  output  1 each  status.

Function
REQ-015 SHALL implement states IDLE, LEN, DATA, WRITE, VERIFY, DONE, ERR.
REQ-016 SHALL move IDLE->LEN on start; start in any state other than IDLE/DONE/ERR is ignored; start in DONE/ERR behaves as in IDLE.
REQ-017 SHALL assert rx_ready only in LEN and DATA; a byte transfers when rx_valid && rx_ready.
REQ-018 SHALL assemble LEN as 4 bytes little-endian word count (first byte = bits 7:0).
REQ-019 SHALL, after 4th LEN byte: count 0 -> DONE; count > MAX_WORDS -> ERR; else -> DATA with word index 0.
REQ-020 SHALL assemble each data word from 4 bytes little-endian, then enter WRITE.
REQ-021 SHALL, in WRITE, assert writeEnable for exactly one cycle with addr = BASE_ADDR + 4*index and writeData = assembled word.
REQ-022 SHALL hold addr/writeData stable from WRITE through VERIFY; writeEnable low outside WRITE.
REQ-023 SHALL, after last word (index = count-1) written/verified, enter DONE; otherwise increment index and return to DATA.
REQ-024 SHALL drive cpu_rstn = 1 only in DONE; busy = 1 in LEN, DATA, WRITE, VERIFY; done = 1 in DONE; error = 1 in ERR.
REQ-025 SHALL wait indefinitely on rx_valid low (no timeout); gaps between bytes do not alter state.
REQ-026 SHALL wrap addr modulo 2^32 (no saturation); byte counter is 2 bits, word index ceil(log2(MAX_WORDS+1)) bits.

Reset
REQ-027 SHALL, on rstn low at posedge clk, enter IDLE regardless of state, abandoning a partial load.
REQ-028 SHALL reset all outputs to 0: rx_ready, writeEnable, addr, writeData, cpu_rstn, busy, done, error.
REQ-029 SHALL keep cpu_rstn low from reset until a load reaches DONE.

Configuration
REQ-030 SHALL, with ROM_LOADER_VERIFY_EN defined, enter VERIFY one cycle after WRITE and compare readData to writeData; mismatch -> ERR, match -> next word/DONE.
REQ-031 SHALL, without ROM_LOADER_VERIFY_EN, never enter VERIFY; WRITE proceeds directly to next word/DONE and readData is unused.

Structure
REQ-032 SHALL place state encoding enum and LEN byte count constant (4) in shared package rom_loader_pkg.
REQ-033 SHALL implement byte-to-word assembly in sub-module byte_packer (4-byte shift register, word_valid pulse); FSM stays in rom_loader.

Verification
REQ-034 SHALL cover: start; bytes 02 00 00 00, 78 56 34 12, EF BE AD DE -> writes 0x12345678@0x0, 0xDEADBEEF@0x4; done=1, cpu_rstn=1.
REQ-035 SHALL cover: length bytes 00 00 00 00 -> no writeEnable, DONE in cycle after 4th byte.
REQ-036 SHALL cover: length 4097 (01 10 00 00) with MAX_WORDS=4096 -> ERR, zero writes, cpu_rstn=0.
REQ-037 SHALL cover: rstn low after 2nd data byte of word 1 -> IDLE, all outputs 0; fresh load then succeeds.
REQ-038 SHALL cover (ROM_LOADER_VERIFY_EN): memory model forces readData=0x0 on word 0 write of 0xA5A5A5A5 -> error=1.
REQ-039 SHALL cover: rx_valid toggled 1-0-1 with 3-cycle gaps and BASE_ADDR=0x100 -> identical data written at 0x100, 0x104.
